// File: rtl/frame_ring_ctrl_if.sv
// Frame RAM bus between the ring controller and the per-bank RAMs.
// One shared read address, per-bank read data, one-hot write port.
interface frame_ring_ctrl_if #(
    parameter int NUM_BANKS   = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 17
);
    logic [ADDR_WIDTH-1:0]            rd_addr;
    logic [NUM_BANKS*PIXEL_WIDTH-1:0] mem_rdata;
    logic [NUM_BANKS-1:0]             wr_en;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [PIXEL_WIDTH-1:0]           wr_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        input  mem_rdata
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        output mem_rdata
    );
endinterface

// File: rtl/frame_ring_ctrl.sv
// Multi-frame ring controller: captures into NUM_FRAMES+1 banks and
// presents an age-ordered pixel window plus one age-selected pixel.
module frame_ring_ctrl #(
    parameter int NUM_FRAMES   = 7,
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 316,
    parameter int IMAGE_HEIGHT = 252,
    parameter int COORD_WIDTH  = 10,
    parameter int ADDR_WIDTH   = 17,
    parameter int MEM_LATENCY  = 1,
    parameter int SEL_WIDTH    = 3
) (
    input  logic                              PixelClk,
    input  logic                              rst_n,
    input  logic [COORD_WIDTH-1:0]            pixel_x,
    input  logic [COORD_WIDTH-1:0]            pixel_y,
    input  logic                              vid_pVDE,
    input  logic                              frame_start,
    input  logic                              cap_valid,
    input  logic [PIXEL_WIDTH-1:0]            cap_pixel,
    input  logic [SEL_WIDTH-1:0]              sel,
    frame_ring_ctrl_if.master                 mem,
    output logic [NUM_FRAMES*PIXEL_WIDTH-1:0] pixels_out,
    output logic [PIXEL_WIDTH-1:0]            pixel_sel,
    output logic                              out_valid,
    output logic [3:0]                        frames_filled,
    output logic                              cap_overflow
);
    localparam int B         = NUM_FRAMES + 1;
    localparam int BW        = $clog2(B);
    localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CW        = $clog2(FRAME_PIX + 1);
    localparam int DL        = MEM_LATENCY + 1;

    localparam logic [CW-1:0]          FULL_CNT  = CW'(FRAME_PIX);
    localparam logic [BW-1:0]          LAST_BANK = BW'(B - 1);
    localparam logic [3:0]             FF_MAX    = 4'(NUM_FRAMES);
    localparam logic [ADDR_WIDTH-1:0]  LINE      = ADDR_WIDTH'(IMAGE_WIDTH);
    localparam logic [COORD_WIDTH-1:0] X_LIM     = COORD_WIDTH'(IMAGE_WIDTH);
    localparam logic [COORD_WIDTH-1:0] Y_LIM     = COORD_WIDTH'(IMAGE_HEIGHT);

    function automatic logic [B-1:0] onehot(input logic [BW-1:0] b);
        logic [B-1:0] one;
        one = {{(B-1){1'b0}}, 1'b1};
        return one << b;
    endfunction

    function automatic logic [BW-1:0] age_bank(
        input logic [BW-1:0] h,
        input int            a
    );
        int b;
        b = int'(h) - a;
        if (b < 0) b = b + B;
        return BW'(b);
    endfunction

    logic [BW-1:0] head;
    logic [BW-1:0] wbank;
    logic [BW-1:0] wbank_nx;
    logic [CW-1:0] cap_cnt;
    logic          cap_full;

    assign wbank    = (head == LAST_BANK) ? '0 : head + 1'b1;
    assign wbank_nx = (wbank == LAST_BANK) ? '0 : wbank + 1'b1;
    assign cap_full = (cap_cnt == FULL_CNT);

    // A pixel arriving with frame_start opens the next capture at address 0.
    always_ff @(posedge PixelClk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            cap_cnt       <= '0;
            frames_filled <= '0;
            cap_overflow  <= 1'b0;
            mem.wr_en     <= '0;
            mem.wr_addr   <= '0;
            mem.wr_data   <= '0;
        end else begin
            mem.wr_en <= '0;
            if (frame_start) begin
                if (cap_full) begin
                    head <= wbank;
                    if (frames_filled < FF_MAX)
                        frames_filled <= frames_filled + 4'd1;
                end
                if (cap_valid) begin
                    mem.wr_en   <= onehot(cap_full ? wbank_nx : wbank);
                    mem.wr_addr <= '0;
                    mem.wr_data <= cap_pixel;
                    cap_cnt     <= CW'(1);
                end else begin
                    cap_cnt <= '0;
                end
            end else if (cap_valid) begin
                if (cap_full) begin
                    cap_overflow <= 1'b1;
                end else begin
                    mem.wr_en   <= onehot(wbank);
                    mem.wr_addr <= ADDR_WIDTH'(cap_cnt);
                    mem.wr_data <= cap_pixel;
                    cap_cnt     <= cap_cnt + 1'b1;
                end
            end
        end
    end

    logic          in_img;
    logic [DL-1:0] vld_d;
    logic [BW-1:0] head_d [DL];
    logic [3:0]    fill_d [DL];

    assign in_img = (pixel_x < X_LIM) && (pixel_y < Y_LIM) && vid_pVDE;

    // Mapping snapshots travel with the address so a rotation never tears.
    always_ff @(posedge PixelClk or negedge rst_n) begin
        if (!rst_n) begin
            mem.rd_addr <= '0;
            vld_d       <= '0;
            for (int i = 0; i < DL; i++) begin
                head_d[i] <= '0;
                fill_d[i] <= '0;
            end
        end else begin
            mem.rd_addr <= in_img
                ? ADDR_WIDTH'(pixel_x) + ADDR_WIDTH'(pixel_y) * LINE
                : '0;
            vld_d     <= {vld_d[DL-2:0], in_img};
            head_d[0] <= head;
            fill_d[0] <= frames_filled;
            for (int i = 1; i < DL; i++) begin
                head_d[i] <= head_d[i-1];
                fill_d[i] <= fill_d[i-1];
            end
        end
    end

    logic [PIXEL_WIDTH-1:0] bank_px [B];
    logic [PIXEL_WIDTH-1:0] age_px  [NUM_FRAMES];
    int                     sel_age;

    always_comb begin
        for (int k = 0; k < B; k++)
            bank_px[k] = mem.mem_rdata[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    always_comb begin
        for (int a = 0; a < NUM_FRAMES; a++) begin
            age_px[a] = '0;
            if (vld_d[DL-1] && (a < int'(fill_d[DL-1])))
                age_px[a] = bank_px[age_bank(head_d[DL-1], a)];
        end
    end

    always_comb begin
        sel_age = int'(sel);
        if (sel_age > NUM_FRAMES - 1) sel_age = NUM_FRAMES - 1;
    end

    always_ff @(posedge PixelClk or negedge rst_n) begin
        if (!rst_n) begin
            pixels_out <= '0;
            pixel_sel  <= '0;
            out_valid  <= 1'b0;
        end else begin
            for (int a = 0; a < NUM_FRAMES; a++)
                pixels_out[a*PIXEL_WIDTH +: PIXEL_WIDTH] <= age_px[a];
            pixel_sel <= age_px[sel_age];
            out_valid <= vld_d[DL-1];
        end
    end
endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Bench for frame_ring_ctrl: 3-frame window over a 4x2 image,
// directed sequences, a vector table and a random run against a frame-queue model.
module tb_frame_ring_ctrl;
    localparam int NF = 3;
    localparam int PW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 4;
    localparam int B  = NF + 1;

    logic          PixelClk = 1'b0;
    logic          rst_n    = 1'b0;
    logic [9:0]    pixel_x  = '0;
    logic [9:0]    pixel_y  = '0;
    logic          vid_pVDE = 1'b0;
    logic          frame_start = 1'b0;
    logic          cap_valid = 1'b0;
    logic [PW-1:0] cap_pixel = '0;
    logic [2:0]    sel = '0;
    logic [NF*PW-1:0] pixels_out;
    logic [PW-1:0] pixel_sel;
    logic          out_valid;
    logic [3:0]    frames_filled;
    logic          cap_overflow;

    frame_ring_ctrl_if #(
        .NUM_BANKS(B), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
    ) mif ();

    frame_ring_ctrl #(
        .NUM_FRAMES(NF), .PIXEL_WIDTH(PW), .IMAGE_WIDTH(W),
        .IMAGE_HEIGHT(H), .COORD_WIDTH(10), .ADDR_WIDTH(AW),
        .MEM_LATENCY(1), .SEL_WIDTH(3)
    ) dut (
        .PixelClk(PixelClk), .rst_n(rst_n),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .vid_pVDE(vid_pVDE), .frame_start(frame_start),
        .cap_valid(cap_valid), .cap_pixel(cap_pixel),
        .sel(sel), .mem(mif),
        .pixels_out(pixels_out), .pixel_sel(pixel_sel),
        .out_valid(out_valid), .frames_filled(frames_filled),
        .cap_overflow(cap_overflow)
    );

    always #5 PixelClk = ~PixelClk;

    // behavioural bank RAMs, one cycle read latency
    logic [PW-1:0] ram [B][8];
    logic [PW-1:0] rdq [B];

    always @(posedge PixelClk) begin
        for (int k = 0; k < B; k++) begin
            if (mif.wr_en[k]) ram[k][mif.wr_addr[2:0]] <= mif.wr_data;
            rdq[k] <= ram[k][mif.rd_addr[2:0]];
        end
    end

    assign mif.mem_rdata = {rdq[3], rdq[2], rdq[1], rdq[0]};

    // reference model: queue of completed frames, newest first
    typedef logic [7:0][7:0] frame_t;
    typedef struct {
        logic        valid;
        logic [23:0] win;
    } pend_t;
    typedef struct {
        int         x;
        int         y;
        bit         vde;
        logic [3:0] addr;
        bit         vld;
    } vec_t;

    frame_t q[$];
    frame_t cur;
    int     cnt;
    int     n_done;
    bit     ovf;
    pend_t  pq[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        pend_t z;
        q.delete();
        pq.delete();
        cur    = '0;
        cnt    = 0;
        n_done = 0;
        ovf    = 0;
        z.valid = 1'b0;
        z.win   = '0;
        pq.push_back(z);
        pq.push_back(z);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rd_addr"}, 64'(mif.rd_addr), 64'(0));
        chk({tag, ".wr_en"}, 64'(mif.wr_en), 64'(0));
        chk({tag, ".wr_addr"}, 64'(mif.wr_addr), 64'(0));
        chk({tag, ".wr_data"}, 64'(mif.wr_data), 64'(0));
        chk({tag, ".pixels_out"}, 64'(pixels_out), 64'(0));
        chk({tag, ".pixel_sel"}, 64'(pixel_sel), 64'(0));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".frames_filled"}, 64'(frames_filled), 64'(0));
        chk({tag, ".cap_overflow"}, 64'(cap_overflow), 64'(0));
    endtask

    task automatic step(input bit fs, input bit cv, input logic [7:0] px,
                        input int x, input int y, input bit vde,
                        input int sl);
        bit    inimg;
        int    addr;
        int    ff;
        int    idx;
        bit    we;
        int    wb;
        int    wa;
        pend_t e;
        pend_t o;
        frame_start = fs;
        cap_valid   = cv;
        cap_pixel   = px;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        vid_pVDE    = vde;
        sel         = 3'(sl);
        inimg = (x < W) && (y < H) && vde;
        addr  = inimg ? x + W * y : 0;
        ff    = (q.size() < NF) ? q.size() : NF;
        e.valid = inimg;
        e.win   = '0;
        for (int a = 0; a < NF; a++)
            if (inimg && a < ff) e.win[a*8 +: 8] = q[a][addr];
        we = 0;
        wb = 0;
        wa = 0;
        if (cv) begin
            if (fs) begin
                we = 1;
                wb = (cnt == W * H) ? (n_done + 2) % B : (n_done + 1) % B;
            end else if (cnt < W * H) begin
                we = 1;
                wa = cnt;
                wb = (n_done + 1) % B;
            end
        end
        if (fs) begin
            if (cnt == W * H) begin
                q.push_front(cur);
                n_done++;
                if (q.size() > NF) void'(q.pop_back());
            end
            cnt = 0;
        end
        if (cv) begin
            if (cnt < W * H) begin
                cur[cnt] = px;
                cnt++;
            end else begin
                ovf = 1;
            end
        end
        pq.push_back(e);
        @(posedge PixelClk);
        #1;
        chk("rd_addr", 64'(mif.rd_addr), 64'(addr));
        chk("wr_en", 64'(mif.wr_en), we ? 64'(1) << wb : 64'(0));
        if (we) begin
            chk("wr_addr", 64'(mif.wr_addr), 64'(wa));
            chk("wr_data", 64'(mif.wr_data), 64'(px));
        end
        ff = (q.size() < NF) ? q.size() : NF;
        chk("frames_filled", 64'(frames_filled), 64'(ff));
        chk("cap_overflow", 64'(cap_overflow), 64'(ovf));
        o = pq.pop_front();
        idx = (sl > NF - 1) ? NF - 1 : sl;
        chk("out_valid", 64'(out_valid), 64'(o.valid));
        chk("pixels_out", 64'(pixels_out), 64'(o.win));
        chk("pixel_sel", 64'(pixel_sel), 64'(o.win[idx*8 +: 8]));
    endtask

    task automatic idle(input int sl);
        step(0, 0, 8'h00, 0, 0, 0, sl);
    endtask

    task automatic raster(input bit cv, input int sl);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                step(0, cv, 8'(8'h60 + x + W * y), x, y, 1, sl);
    endtask

    task automatic do_reset();
        frame_start = 0;
        cap_valid   = 0;
        rst_n       = 0;
        #1;
        check_zero("async_rst");
        @(posedge PixelClk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0, 0, 1, 4'd0, 1};
        tbl[1] = '{3, 1, 1, 4'd7, 1};
        tbl[2] = '{4, 0, 1, 4'd0, 0};
        tbl[3] = '{0, 2, 1, 4'd0, 0};
        tbl[4] = '{2, 1, 0, 4'd0, 0};
        tbl[5] = '{1, 1, 1, 4'd5, 1};
        tbl[6] = '{4, 2, 1, 4'd0, 0};
        tbl[7] = '{3, 0, 1, 4'd3, 1};
        tbl[8] = '{0, 0, 0, 4'd0, 0};
        tbl[9] = '{0, 0, 0, 4'd0, 0};

        // 1: reset and empty ring
        model_reset();
        repeat (3) @(posedge PixelClk);
        #1;
        check_zero("reset");
        rst_n = 1;
        raster(0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i), i, 0, 1, 0);
        do_reset();
        raster(0, 0);
        idle(0);
        idle(0);

        // 2: single frame then rotation
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'(8'h10 + i), 0, 0, 0, 0);
            chk("t2.wr_en", 64'(mif.wr_en), 64'h2);
        end
        step(1, 0, 8'h00, 0, 0, 0, 0);
        chk("t2.frames_filled", 64'(frames_filled), 64'd1);
        raster(0, 0);
        chk("t2.rd_addr_3_1", 64'(mif.rd_addr), 64'd7);
        idle(0);
        idle(0);
        chk("t2.window", 64'(pixels_out), 64'h000017);

        // 3: ring wrap and saturation
        for (int f = 1; f <= 5; f++) begin
            for (int i = 0; i < 8; i++) begin
                step(0, 1, 8'(f), 0, 0, 0, 0);
                if (i == 0)
                    chk("t3.wr_en", 64'(mif.wr_en), 64'(1) << ((f + 1) % B));
            end
            step(1, 0, 8'h00, 0, 0, 0, 0);
        end
        chk("t3.frames_filled", 64'(frames_filled), 64'd3);
        raster(0, 7);
        idle(7);
        idle(7);
        chk("t3.window", 64'(pixels_out), 64'h030405);
        chk("t3.sel_clamp", 64'(pixel_sel), 64'h03);

        // 4: partial frame, then overflow
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hA0 + i), 0, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        chk("t4.frames_filled", 64'(frames_filled), 64'd3);
        raster(0, 7);
        idle(7);
        idle(7);
        chk("t4.window", 64'(pixels_out), 64'h030405);
        step(0, 1, 8'hB0, 0, 0, 0, 0);
        chk("t4.restart_addr", 64'(mif.wr_addr), 64'd0);
        chk("t4.restart_bank", 64'(mif.wr_en), 64'h8);
        for (int i = 1; i < 9; i++) step(0, 1, 8'(8'hB0 + i), 0, 0, 0, 0);
        chk("t4.drop_wr_en", 64'(mif.wr_en), 64'h0);
        chk("t4.overflow", 64'(cap_overflow), 64'h1);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        idle(0);
        idle(0);
        chk("t4.overflow_sticky", 64'(cap_overflow), 64'h1);

        // 5: simultaneous capture and rotation
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'(8'hC0 + i), 0, 0, 0, 0);
            if (i == 0) chk("t5.wr_en", 64'(mif.wr_en), 64'h1);
        end
        step(1, 1, 8'h55, 0, 0, 0, 0);
        chk("t5.fs_cv_bank", 64'(mif.wr_en), 64'h2);
        chk("t5.fs_cv_addr", 64'(mif.wr_addr), 64'd0);
        chk("t5.fs_cv_data", 64'(mif.wr_data), 64'h55);
        for (int i = 1; i < 8; i++) step(0, 1, 8'(8'h55 + i), 0, 0, 0, 0);

        // out-of-image vectors
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, tbl[i].x, tbl[i].y, tbl[i].vde, 0);
            chk("tbl.rd_addr", 64'(mif.rd_addr), 64'(tbl[i].addr));
            if (i >= 2) begin
                chk("tbl.out_valid", 64'(out_valid), 64'(tbl[i-2].vld));
                if (!tbl[i-2].vld)
                    chk("tbl.pixels_zero", 64'(pixels_out), 64'h0);
            end
        end

        // rotation in the middle of an active line
        step(0, 0, 8'h00, 0, 0, 1, 0);
        step(0, 0, 8'h00, 1, 0, 1, 0);
        step(1, 0, 8'h00, 2, 0, 1, 0);
        chk("t5.old_map_x0", 64'(pixel_sel), 64'hC0);
        step(0, 0, 8'h00, 3, 0, 1, 0);
        chk("t5.old_map_x1", 64'(pixel_sel), 64'hC1);
        idle(0);
        chk("t5.old_map_x2", 64'(pixel_sel), 64'hC2);
        idle(0);
        chk("t5.new_map_x3", 64'(pixel_sel), 64'h58);

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            step($urandom_range(11) == 0,
                 $urandom_range(3) != 0,
                 8'($urandom),
                 int'($urandom_range(5)),
                 int'($urandom_range(3)),
                 $urandom_range(4) != 0,
                 int'($urandom_range(7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
